// File: rtl/div_issuer_if.sv
// Bundle of the issue, divider-request and writeback signals of div_issuer.
// slave is the issuer's view; master is the surrounding pipeline/divider view.
interface div_issuer_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_op;
    logic [4:0]       issue_rd;
    logic [WIDTH-1:0] issue_src1;
    logic [WIDTH-1:0] issue_src2;
    logic [3:0]       pipeline_divider_type;
    logic [4:0]       pipeline_divider_subtype;
    logic             pipeline_divider_stall;
    logic             pipeline_divider_flush;
    logic [WIDTH-1:0] pipeline_divider_din1;
    logic [WIDTH-1:0] pipeline_divider_din2;
    logic             divider_pipeline_stall;
    logic [WIDTH-1:0] divider_pipeline_dout;
    logic             wb_valid;
    logic             wb_ready;
    logic [4:0]       wb_rd;
    logic [WIDTH-1:0] wb_data;

    modport slave (
        input  flush, issue_valid, issue_op, issue_rd, issue_src1, issue_src2,
        input  divider_pipeline_stall, divider_pipeline_dout, wb_ready,
        output issue_ready, pipeline_divider_type, pipeline_divider_subtype,
        output pipeline_divider_stall, pipeline_divider_flush,
        output pipeline_divider_din1, pipeline_divider_din2,
        output wb_valid, wb_rd, wb_data
    );

    modport master (
        output flush, issue_valid, issue_op, issue_rd, issue_src1, issue_src2,
        output divider_pipeline_stall, divider_pipeline_dout, wb_ready,
        input  issue_ready, pipeline_divider_type, pipeline_divider_subtype,
        input  pipeline_divider_stall, pipeline_divider_flush,
        input  pipeline_divider_din1, pipeline_divider_din2,
        input  wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/div_issuer.sv
// Issues one 32-bit divide/modulo at a time to a shared iterative divider and
// holds the result for writeback; zero divisors are resolved locally.
module div_issuer #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rstn,
    div_issuer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_p0;
    state_t           state_nxt;
    logic [1:0]       op_p0;
    logic [4:0]       rd_p0;
    logic [WIDTH-1:0] src1_p0;
    logic [WIDTH-1:0] src2_p0;
    logic             seen_busy_p0;
    logic [WIDTH-1:0] wb_data_p1;

    logic             ready_c;
    logic             accept;
    logic             zero_div;
    logic             capture;

    // DIV by zero gives 0, MOD by zero returns the dividend.
    function automatic logic [WIDTH-1:0] zero_div_result(input logic [1:0] op,
                                                         input logic [WIDTH-1:0] dividend);
        return op[0] ? dividend : '0;
    endfunction

    always_comb begin
        ready_c   = (state_p0 == S_IDLE) || ((state_p0 == S_DONE) && bus.wb_ready);
        accept    = bus.issue_valid && ready_c && !bus.flush;
        zero_div  = (bus.issue_src2 == '0);
        // The divider only counts as finished after it has been seen busy.
        capture   = (state_p0 == S_WAIT) && seen_busy_p0 && !bus.divider_pipeline_stall;
        state_nxt = state_p0;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state_p0)
                S_IDLE:   if (accept) state_nxt = zero_div ? S_DONE : S_LAUNCH;
                S_LAUNCH: state_nxt = S_WAIT;
                S_WAIT:   if (capture) state_nxt = S_DONE;
                S_DONE: begin
                    if (bus.wb_ready) begin
                        if (accept) state_nxt = zero_div ? S_DONE : S_LAUNCH;
                        else        state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.issue_ready              = ready_c;
        bus.pipeline_divider_type    = (state_p0 == S_LAUNCH) ? 4'd2 : 4'd0;
        bus.pipeline_divider_subtype = {3'b000, op_p0};
        bus.pipeline_divider_stall   = !((state_p0 == S_LAUNCH) || capture);
        bus.pipeline_divider_flush   = bus.flush && rstn;
        bus.pipeline_divider_din1    = src1_p0;
        bus.pipeline_divider_din2    = src2_p0;
        bus.wb_valid                 = (state_p0 == S_DONE);
        bus.wb_rd                    = rd_p0;
        bus.wb_data                  = wb_data_p1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_p0 <= S_IDLE;
        else       state_p0 <= state_nxt;
    end

    // p0: accepted operation
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_p0        <= '0;
            rd_p0        <= '0;
            src1_p0      <= '0;
            src2_p0      <= '0;
            seen_busy_p0 <= 1'b0;
        end else begin
            if (accept) begin
                op_p0   <= bus.issue_op;
                rd_p0   <= bus.issue_rd;
                src1_p0 <= bus.issue_src1;
                src2_p0 <= bus.issue_src2;
            end
            if (state_p0 == S_LAUNCH)
                seen_busy_p0 <= 1'b0;
            else if ((state_p0 == S_WAIT) && bus.divider_pipeline_stall)
                seen_busy_p0 <= 1'b1;
        end
    end

    // p1: writeback result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_data_p1 <= '0;
        end else if (accept && zero_div) begin
            wb_data_p1 <= zero_div_result(bus.issue_op, bus.issue_src1);
        end else if (capture && !bus.flush) begin
            wb_data_p1 <= bus.divider_pipeline_dout;
        end
    end

endmodule

// File: tb/tb_div_issuer.sv
// Scoreboard bench for div_issuer with a behavioural multi-cycle divider.
module tb_div_issuer;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_launch = 0;
    int   n_wb = 0;
    int   lat = 2;
    bit   rnd_phase = 1'b0;
    exp_t sb[$];
    int   hs_q[$];
    int   launch_q[$];

    div_issuer_if #(.WIDTH(32)) bus ();

    div_issuer #(.WIDTH(32)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sd;
        sa = a;
        sd = b;
        if (b == 32'd0) return op[0] ? a : 32'd0;
        case (op)
            2'd0:    return sa / sd;
            2'd1:    return sa % sd;
            2'd2:    return a / b;
            default: return a % b;
        endcase
    endfunction

    // Divider: busy for lat WAIT cycles after a request, then result with stall low.
    initial begin
        int          cnt;
        bit          busy;
        logic [31:0] res;
        cnt = 0;
        busy = 1'b0;
        res = '0;
        bus.divider_pipeline_stall = 1'b0;
        bus.divider_pipeline_dout  = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (!rstn || bus.pipeline_divider_flush) begin
                busy = 1'b0;
                bus.divider_pipeline_stall = 1'b0;
            end else if (bus.pipeline_divider_type == 4'd2) begin
                busy = 1'b1;
                cnt  = lat;
                res  = ref_result(bus.pipeline_divider_subtype[1:0],
                                  bus.pipeline_divider_din1, bus.pipeline_divider_din2);
                bus.divider_pipeline_stall = 1'b1;
                bus.divider_pipeline_dout  = 32'hDEAD_BEEF;
            end else if (busy) begin
                if (cnt == 0) begin
                    busy = 1'b0;
                    bus.divider_pipeline_stall = 1'b0;
                    bus.divider_pipeline_dout  = res;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Writeback monitor and launch recorder
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (rstn) begin
                if (bus.pipeline_divider_type == 4'd2) begin
                    n_launch++;
                    launch_q.push_back(cyc);
                end
                if (bus.wb_valid && bus.wb_ready) begin
                    n_wb++;
                    hs_q.push_back(cyc);
                    if (sb.size() == 0) begin
                        chk("wb_unexpected", 32'(bus.wb_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
                        chk("wb_data", bus.wb_data, e.data);
                    end
                end
            end
        end
    end

    // Random writeback backpressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_phase) bus.wb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_data);
        int   w;
        exp_t e;
        bus.issue_op    = op;
        bus.issue_rd    = rd;
        bus.issue_src1  = a;
        bus.issue_src2  = b;
        bus.issue_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.issue_ready && w < 300);
        if (!bus.issue_ready) begin
            chk("issue_timeout", 32'(w), 32'd0);
            bus.issue_valid = 1'b0;
            return;
        end
        e.rd   = rd;
        e.data = exp_data;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          l0;
        int          bh;
        int          bl;
        int          w;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.flush       = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_op    = 2'd0;
        bus.issue_rd    = 5'd0;
        bus.issue_src1  = 32'd0;
        bus.issue_src2  = 32'd0;
        bus.wb_ready    = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_type", 32'(bus.pipeline_divider_type), 32'd0);
        chk("rst_subtype", 32'(bus.pipeline_divider_subtype), 32'd0);
        chk("rst_din1", bus.pipeline_divider_din1, 32'd0);
        chk("rst_din2", bus.pipeline_divider_din2, 32'd0);
        chk("rst_stall", 32'(bus.pipeline_divider_stall), 32'd1);
        chk("rst_pflush", 32'(bus.pipeline_divider_flush), 32'd0);
        bus.flush = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.issue_ready), 32'd1);
        @(posedge clk);
        #1;

        // DIVW 100/7: exactly one request pulse
        l0 = n_launch;
        issue_op(2'd0, 5'd5, 32'd100, 32'd7, 32'd14);
        drain();
        chk("divw_launch_cnt", 32'(n_launch - l0), 32'd1);

        issue_op(2'd1, 5'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        issue_op(2'd2, 5'd7, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        drain();

        // Zero divisor: local result one cycle after accept, divider untouched
        l0 = n_launch;
        issue_op(2'd3, 5'd8, 32'd5, 32'd0, 32'd5);
        @(negedge clk);
        chk("zd_latency", 32'(bus.wb_valid), 32'd1);
        drain();
        issue_op(2'd0, 5'd9, 32'd5, 32'd0, 32'd0);
        drain();
        chk("zd_no_launch", 32'(n_launch - l0), 32'd0);

        // Flush in the third WAIT cycle
        lat = 4;
        bh = n_wb;
        issue_op(2'd0, 5'd11, 32'd1000, 32'd3, 32'd333);
        @(negedge clk);
        chk("flush_launch", 32'(bus.pipeline_divider_type), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_pflush", 32'(bus.pipeline_divider_flush), 32'd1);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        sb.delete();
        repeat (6) begin
            @(negedge clk);
            chk("flush_no_wb", 32'(bus.wb_valid), 32'd0);
        end
        chk("flush_wb_cnt", 32'(n_wb - bh), 32'd0);
        @(posedge clk);
        #1;
        lat = 2;
        issue_op(2'd0, 5'd12, 32'd9, 32'd3, 32'd3);
        drain();

        // Writeback backpressure: result held, no accept until wb_ready
        bus.wb_ready = 1'b0;
        issue_op(2'd0, 5'd9, 32'd77, 32'd5, 32'd15);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.wb_valid && w < 100);
        chk("hold_reach_done", 32'(bus.wb_valid), 32'd1);
        bus.issue_op    = 2'd0;
        bus.issue_rd    = 5'd10;
        bus.issue_src1  = 32'd20;
        bus.issue_src2  = 32'd4;
        bus.issue_valid = 1'b1;
        repeat (10) begin
            chk("hold_valid", 32'(bus.wb_valid), 32'd1);
            chk("hold_data", bus.wb_data, 32'd15);
            chk("hold_rd", 32'(bus.wb_rd), 32'd9);
            chk("hold_stall", 32'(bus.pipeline_divider_stall), 32'd1);
            chk("hold_ready", 32'(bus.issue_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b1;
        issue_op(2'd0, 5'd10, 32'd20, 32'd4, 32'd5);
        drain();

        // Back-to-back: second launch right after the first handshake
        bh = hs_q.size();
        bl = launch_q.size();
        issue_op(2'd2, 5'd13, 32'd8, 32'd2, 32'd4);
        issue_op(2'd2, 5'd14, 32'd9, 32'd4, 32'd2);
        drain();
        if (hs_q.size() > bh && launch_q.size() > bl + 1)
            chk("b2b_launch_cyc", 32'(launch_q[bl+1]), 32'(hs_q[bh] + 1));
        else
            chk("b2b_events", 32'(launch_q.size() - bl), 32'd2);

        // Reset in the middle of an operation
        lat = 4;
        bh = n_wb;
        issue_op(2'd0, 5'd3, 32'd50, 32'd5, 32'd10);
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        #1;
        chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("midrst_stall", 32'(bus.pipeline_divider_stall), 32'd1);
        chk("midrst_type", 32'(bus.pipeline_divider_type), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("midrst_no_wb", 32'(bus.wb_valid), 32'd0);
        end
        chk("midrst_wb_cnt", 32'(n_wb - bh), 32'd0);
        @(posedge clk);
        #1;
        lat = 2;
        issue_op(2'd0, 5'd3, 32'd50, 32'd5, 32'd10);
        drain();

        // Random mix with random divider latency and backpressure
        rnd_phase = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'd0 - 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            lat = $urandom_range(1, 4);
            issue_op(rop, 5'($urandom_range(0, 31)), ra, rb, ref_result(rop, ra, rb));
        end
        rnd_phase = 1'b0;
        @(posedge clk);
        #1;
        bus.wb_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
